fifo_uart_tx: RTL
=================

# fifo_uart_tx

Drains bytes from the receive FIFO and re-serialises them as 8N1 UART frames on a TX pin, giving the board a loopback/echo path (RX → rxuartlite → ufifo → fifo_uart_tx → TX). It sits directly downstream of ufifo. It pops one byte per frame through the FIFO's read strobe and shifts it out LSB-first at a fixed baud rate. Back-to-back frames run with no idle gap while the FIFO is non-empty and the block is enabled.

## Interface
- CLOCKS_PER_BAUD, 24'd104, clock cycles per bit period; legal range 2 to 2^24-1.
- NSTOP, 1, number of stop bits; legal values 1 or 2.

- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  drain enable; a new pop is allowed only while high.
- i_empty_n  in  1  FIFO non-empty flag (ufifo o_empty_n).
- i_data  in  8  FIFO head byte (ufifo o_data), valid whenever i_empty_n=1.
- o_rd  out  1  one-cycle pop strobe to the FIFO (ufifo i_rd).
- o_uart_tx  out  1  serial line, idle high.
- o_busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.

## Operation
- Reset values: o_uart_tx=1, o_rd=0, o_busy=0, state IDLE, baud counter 0, bit counter 0, shift register 0x00.
- States:
  - IDLE → START when i_en & i_empty_n.
  - START → DATA after one bit period.
  - DATA → STOP after 8 bit periods.
  - STOP → IDLE or START after NSTOP bit periods.
- Pop rule: in the cycle the FSM leaves IDLE, or leaves the last STOP cycle, with i_en & i_empty_n:
  - o_rd=1 for exactly that cycle.
  - i_data is captured into the shift register in that same cycle.
- o_rd is never asserted while i_empty_n=0 or i_en=0. At most one pop per frame.
- Line levels: START drives 0. DATA drives shift[0] and shifts right each bit period (LSB first). STOP drives 1. IDLE drives 1.
- Baud counter is 24 bits. It loads 0 at each bit start and wraps at CLOCKS_PER_BAUD-1 to advance the bit.
- Bit counter is 3 bits, 0..7 in DATA. A separate stop counter runs 0..NSTOP-1.
- i_en falling mid-frame: the current frame completes normally; no further pop.
- i_empty_n falling mid-frame: no effect on the current frame.
- Reset mid-frame, asynchronous:
  - o_uart_tx returns to 1 and o_busy to 0 immediately.
  - The byte already popped is discarded; the FIFO is not re-read.

## Timing
- Pop at cycle T, with o_rd high in T:
  - o_uart_tx goes low and o_busy goes high at T+1.
  - Start bit occupies T+1 .. T+CLOCKS_PER_BAUD.
- Data bit k occupies T+1+(k+1)·CPB .. T+(k+2)·CPB.
- Frame length is exactly (9+NSTOP)·CLOCKS_PER_BAUD cycles.
- Back-to-back: if the FIFO is non-empty in the last stop cycle, o_rd pulses in that cycle. The next start bit begins the following cycle (zero idle cycles).
- From IDLE: latency from i_empty_n rising (with i_en=1) to o_rd is 0 cycles (combinational on registered state); the start bit follows 1 cycle later.
- All outputs are registered except o_rd, which is decoded from state, counters and inputs and is glitch-free at the clock edge.

## Structure
- Shared header uart_const.vh holds:
  - the state encodings (IDLE/START/DATA/STOP, 2-bit);
  - the default CLOCKS_PER_BAUD (24'd104), also used by rxuartlite.
- One sub-module, baud_counter:
  - 24-bit counter with synchronous restart;
  - emits a one-cycle tick at CLOCKS_PER_BAUD-1;
  - asynchronous active-low reset.
- The FSM, shift register and bit/stop counters live in fifo_uart_tx.

## Test plan
Bench uses CLOCKS_PER_BAUD=4, NSTOP=1, and a behavioural FIFO model.
- Reset with FIFO empty → o_uart_tx=1, o_rd=0, o_busy=0 for 100 cycles.
- Single byte 0xA5, i_en=1 → one o_rd pulse; o_busy high for 40 cycles. Line reads 0 (4 cycles), then bits 1,0,1,0,0,1,0,1 (4 each), then 1 (4).
- Bytes 0x00 then 0xFF queued → two o_rd pulses 40 cycles apart; o_busy high continuously for 80 cycles. The stop bit is followed immediately by the second start bit.
- Three bytes queued, i_en dropped during frame 1 data bit 2 → frame 1 completes; exactly one o_rd total; two bytes remain in FIFO. Raising i_en → 0x?? frames 2 and 3 follow.
- i_rst_n low during data bit 3 of 0x3C → o_uart_tx=1 and o_busy=0 before the next clock edge. After release with FIFO empty, the block stays idle and the FIFO count is unchanged.
- NSTOP=2, byte 0x80 → frame 44 cycles; stop high for 8 cycles before the next start.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and defaults for the FIFO-drain UART transmitter.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
`timescale 1ns/1ps
package fifo_uart_tx_pkg;

   // Transmitter FSM encoding (2-bit), shared with the receive side.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Default bit period in system clocks; the receiver uses the same value.
   localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd104;
   localparam int          DEFAULT_NSTOP           = 1;

   // Serial line level for a given state: start low, data from the shifter,
   // stop and idle high.
   function automatic logic line_level(input tx_state_t st, input logic data_bit);
      case (st)
         ST_START: return 1'b0;
         ST_DATA:  return data_bit;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO-read and serial-output bundle for fifo_uart_tx.
// Latency: n/a (wiring only).
// Backpressure: pop strobe rd is issued by the transmitter only when en & empty_n.
// Signals:
//   en      drain enable (environment -> transmitter)
//   empty_n FIFO non-empty flag, data FIFO head byte
//   rd      one-cycle pop strobe, uart_tx serial line, busy frame in progress
`timescale 1ns/1ps
interface fifo_uart_tx_if;
   logic       en;
   logic       empty_n;
   logic [7:0] data;
   logic       rd;
   logic       uart_tx;
   logic       busy;

   // master: the transmitter, which initiates pops from the FIFO.
   modport master (input en, empty_n, data, output rd, uart_tx, busy);
   // slave: the FIFO / environment side.
   modport slave  (output en, empty_n, data, input rd, uart_tx, busy);
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLOCKS_PER_BAUD-1 and flags the last cycle.
// Latency: tick is combinational on the registered count; restart takes effect next cycle.
// Backpressure: none; restart holds the count at 0.
// Ports: clk, rst_n (async active-low), restart (sync clear), tick (last cycle of period).
`timescale 1ns/1ps
module fifo_uart_tx_baud_counter
   import fifo_uart_tx_pkg::*;
#(
   parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   logic [23:0] cnt_q;

   assign tick = (cnt_q == (CLOCKS_PER_BAUD - 24'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 24'd0;
      end else if (restart || tick) begin
         cnt_q <= 24'd0;
      end else begin
         cnt_q <= cnt_q + 24'd1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an upstream FIFO and sends each as an 8N1 (or 8N2) UART frame, LSB first.
// Latency: pop is combinational from IDLE; start bit begins the cycle after the pop.
// Backpressure: pops only while en & empty_n; frames chain with no idle gap.
// Ports: clk, rst_n (async active-low), tx (master modport: en, empty_n, data in;
//        rd pop strobe, uart_tx line, busy out).
`timescale 1ns/1ps
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
   parameter int          NSTOP           = DEFAULT_NSTOP
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_uart_tx_if.master tx
);

   // One stop-counter bit covers both legal stop lengths (1 or 2).
   localparam logic STOP_LAST = 1'(NSTOP - 1);

   tx_state_t  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_q,   bit_d;
   logic       stop_q,  stop_d;
   logic       line_q,  line_d;
   logic       busy_q,  busy_d;

   logic       tick;
   logic       baud_restart;
   logic       frame_end;
   logic       pop;

   // Counter is parked at 0 while idle so the first start bit gets a full period;
   // between chained frames it simply wraps into the next start bit.
   assign baud_restart = (state_q == ST_IDLE);

   fifo_uart_tx_baud_counter #(
      .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (baud_restart),
      .tick    (tick)
   );

   // Last cycle of the last stop bit: the only mid-stream point where a pop may occur.
   assign frame_end = (state_q == ST_STOP) && tick && (stop_q == STOP_LAST);
   assign pop       = ((state_q == ST_IDLE) || frame_end) && tx.en && tx.empty_n;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d = ST_START;
               shift_d = tx.data;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               bit_d   = 3'd0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  stop_d  = 1'b0;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (stop_q == STOP_LAST) begin
                  stop_d = 1'b0;
                  if (pop) begin
                     state_d = ST_START;
                     shift_d = tx.data;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Line and busy are registered from the next state so they change
      // exactly on the bit boundary without any decode glitch.
      busy_d = (state_d != ST_IDLE);
      line_d = line_level(state_d, shift_d[0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= 8'h00;
         bit_q   <= 3'd0;
         stop_q  <= 1'b0;
         line_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         line_q  <= line_d;
         busy_q  <= busy_d;
      end
   end

   assign tx.rd      = pop;
   assign tx.uart_tx = line_q;
   assign tx.busy    = busy_q;

endmodule
